uint_to_ascii: RTL and testbench
================================

UINT_TO_ASCII -- requirements
Module: uint_to_ascii

Interface
REQ-001 SHALL have parameter WIDTH, default 32, input value width; legal range 4..32; output is always up to 10 decimal digits.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_data is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a value (high only in IDLE).
REQ-006 SHALL have port in_data  input  WIDTH  binary value to convert.
REQ-007 SHALL have port char_valid  output  1  char_data holds a valid ASCII character.
REQ-008 SHALL have port char_ready  input  1  downstream accepts char_data.
REQ-009 SHALL have port char_data  output  8  ASCII character, '0'..'9' (0x30..0x39), or '-' (0x2D) when signed mode is compiled in.
REQ-010 SHALL have port char_last  output  1  high with the final character of a number.

Function
REQ-011 SHALL accept input on a rising edge where in_valid && in_ready; in_data is captured on that edge.
REQ-012 SHALL use states IDLE -> CONVERT -> EMIT -> IDLE; no other states are reachable.
REQ-013 CONVERT SHALL run double-dabble (add 3 to any BCD nibble >= 5, then shift left) for exactly WIDTH cycles into a 40-bit BCD register.
REQ-014 On leaving CONVERT, SHALL locate the most significant nonzero digit (digit 0 if all digits are zero) and enter EMIT.
REQ-015 char_valid SHALL first assert WIDTH+1 cycles after the accepting edge.
REQ-016 SHALL emit digits MSB-first with no leading zeros; value 0 emits the single character '0'.
REQ-017 A character transfers on an edge where char_valid && char_ready; char_data and char_last SHALL hold stable while char_valid && !char_ready.
REQ-018 char_last SHALL be high only with the least significant digit.
REQ-019 After the char_last transfer, SHALL return to IDLE; in_ready SHALL be high the next cycle, giving no back-to-back overlap.
REQ-020 in_valid is ignored outside IDLE, and in_data changes outside IDLE have no effect.
REQ-021 With char_ready held high, one character SHALL be emitted per cycle.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, in_ready=1, char_valid=0, char_data=0x00, char_last=0, and clear the BCD and shift registers.
REQ-023 Reset mid-CONVERT or mid-EMIT SHALL abandon the number; no further characters of it appear after rst_n rises.
REQ-024 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro UINT_TO_ASCII_SIGNED_EN defined: in_data SHALL be treated as two's complement; a negative value emits '-' first, then the digits of its magnitude; the most negative value emits its full magnitude (e.g. WIDTH=32: "-2147483648"); latency is unchanged, with '-' being the first character.
REQ-026 Macro not defined: in_data SHALL be unsigned and '-' is never produced.

Verification
REQ-027 Unsigned, WIDTH=32, char_ready=1: in_data=0 -> '0' with char_last, first char_valid at accept+33 cycles.
REQ-028 Unsigned: 10 -> '1','0'; 3 -> '3'; 0xFFFF -> '6','5','5','3','5'; 0xFFFFFFFF -> "4294967295", 10 chars, last on the final '5'.
REQ-029 Signed build: 0xFFFFFFFF -> '-','1'; 0x80000000 -> "-2147483648"; 0x7FFFFFFF -> "2147483647".
REQ-030 Backpressure: 12345 with char_ready toggling randomly -> sequence "12345" intact, char_data stable while stalled, in_ready low until after '5' transfers.
REQ-031 Ignored input: in_valid held high with new in_data during EMIT -> no capture; next accept occurs only in IDLE.
REQ-032 Reset: assert rst_n=0 after the 2nd character of 65535 -> outputs at reset values at once; after release, 7 -> '7' only.

Source files
------------

// File: rtl/uint_to_ascii.sv
// Binary-to-decimal ASCII streamer: double-dabble conversion, then one character per handshake.
// Define UINT_TO_ASCII_SIGNED_EN to treat in_data as two's complement and prefix '-' on negatives.
module uint_to_ascii #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             char_valid,
  input  logic             char_ready,
  output logic [7:0]       char_data,
  output logic             char_last
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [39:0]      bcd_reg;
  logic [39:0]      bcd_adj;
  logic [CW-1:0]    cnt;
  logic [3:0]       digit_idx;
  logic [3:0]       msd;
  logic [WIDTH-1:0] magnitude;
  logic             sign_pending;
  logic             conv_done;
  logic             xfer;

`ifdef UINT_TO_ASCII_SIGNED_EN
  // Negating the most negative value yields itself, which read unsigned is the correct magnitude.
  assign magnitude = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_pending <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign_pending <= in_data[WIDTH-1];
    end else if (xfer) begin
      sign_pending <= 1'b0;
    end
  end
`else
  assign magnitude    = in_data;
  assign sign_pending = 1'b0;
`endif

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    msd = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (bcd_reg[i*4 +: 4] != 4'd0) msd = 4'(i);
    end
  end

  assign conv_done  = (cnt == CW'(WIDTH));
  assign in_ready   = (state == IDLE);
  assign char_valid = (state == EMIT);
  assign char_last  = char_valid && !sign_pending && (digit_idx == 4'd0);
  assign xfer       = char_valid && char_ready;

  always_comb begin
    char_data = 8'h00;
    if (char_valid) begin
      char_data = sign_pending ? 8'h2D : {4'h3, bcd_reg[{digit_idx, 2'b00} +: 4]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONVERT;
      CONVERT: if (conv_done) state_next = EMIT;
      EMIT:    if (xfer && char_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CONVERT spends WIDTH cycles shifting and one more cycle latching the leading digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt       <= '0;
      digit_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= magnitude;
            bcd_reg   <= '0;
            cnt       <= '0;
          end
        end
        CONVERT: begin
          if (!conv_done) begin
            shift_reg <= shift_reg << 1;
            bcd_reg   <= {bcd_adj[38:0], shift_reg[WIDTH-1]};
            cnt       <= cnt + CW'(1);
          end else begin
            digit_idx <= msd;
          end
        end
        EMIT: begin
          if (xfer && !sign_pending && digit_idx != 4'd0) digit_idx <= digit_idx - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uint_to_ascii.sv
// Directed bench for uint_to_ascii (WIDTH=32): vector table, backpressure, ignored input, mid-number reset.
module tb_uint_to_ascii;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        char_valid;
  logic        char_ready = 1'b0;
  logic [7:0]  char_data;
  logic        char_last;

  int checks = 0;
  int failures = 0;

  uint_to_ascii #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_last(char_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_char_valid"}, 64'(char_valid), 64'd0);
    check({tag, "_char_data"}, 64'(char_data), 64'h00);
    check({tag, "_char_last"}, 64'(char_last), 64'd0);
  endtask

  // Accept one value, collect its characters and compare against exp.
  task automatic run_number(input logic [31:0] val, input string exp, input bit rnd, input bit hold);
    int         lat;
    int         cyc;
    int         last_idx;
    int         bad_idx;
    bit         done;
    bit         stalled;
    bit         rdy_bad;
    bit         stable_bad;
    logic [7:0] pd;
    logic       pl;
    logic [7:0] got[$];
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    in_data  = val;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    rdy_bad = 1'b0;
    while (!char_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    check($sformatf("latency_%0h", val), 64'(lat), 64'd33);
    cyc = 0; last_idx = -1; done = 1'b0; stalled = 1'b0; stable_bad = 1'b0;
    pd = '0; pl = 1'b0;
    while (!done && cyc < 200) begin
      if (hold) begin
        in_valid = 1'b1;
        in_data  = 32'd999;
      end
      if (in_ready) rdy_bad = 1'b1;
      if (stalled && (char_data !== pd || char_last !== pl)) stable_bad = 1'b1;
      char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (char_valid && char_ready) begin
        got.push_back(char_data);
        if (char_last) begin
          last_idx = got.size() - 1;
          done = 1'b1;
        end
      end else if (char_valid) begin
        stalled = 1'b1;
        pd = char_data;
        pl = char_last;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    char_ready = 1'b0;
    bad_idx = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++) begin
      if (bad_idx < 0 && got[i] !== exp[i]) bad_idx = i;
    end
    check($sformatf("done_%s", exp), 64'(done), 64'd1);
    check($sformatf("length_%s", exp), 64'(got.size()), 64'(exp.len()));
    check($sformatf("first_bad_char_idx_%s", exp), 64'(bad_idx), 64'(-1));
    check($sformatf("last_idx_%s", exp), 64'(last_idx), 64'(exp.len() - 1));
    check($sformatf("in_ready_low_busy_%s", exp), 64'(rdy_bad), 64'd0);
    check($sformatf("in_ready_after_%s", exp), 64'(in_ready), 64'd1);
    check($sformatf("char_valid_after_%s", exp), 64'(char_valid), 64'd0);
    if (rnd) check($sformatf("stall_stable_%s", exp), 64'(stable_bad), 64'd0);
    else     check($sformatf("throughput_%s", exp), 64'(cyc), 64'(exp.len()));
    if (hold) begin
      @(posedge clk); #1;
      check("no_capture_during_emit", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    vec_t vecs[$];
`ifdef UINT_TO_ASCII_SIGNED_EN
    vecs.push_back('{32'hFFFFFFFF, "-1"});
    vecs.push_back('{32'h80000000, "-2147483648"});
    vecs.push_back('{32'h7FFFFFFF, "2147483647"});
    vecs.push_back('{32'd0, "0"});
    vecs.push_back('{32'd10, "10"});
    vecs.push_back('{32'hFFFFFF85, "-123"});
`else
    vecs.push_back('{32'd0, "0"});
    vecs.push_back('{32'd10, "10"});
    vecs.push_back('{32'd3, "3"});
    vecs.push_back('{32'h0000FFFF, "65535"});
    vecs.push_back('{32'hFFFFFFFF, "4294967295"});
    vecs.push_back('{32'd1000000000, "1000000000"});
    vecs.push_back('{32'd9, "9"});
`endif

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_number(vecs[i].val, vecs[i].exp, 1'b0, 1'b0);

    // Backpressure with random stalls, then in_valid held high during emission.
    run_number(32'd12345, "12345", 1'b1, 1'b0);
    run_number(32'd12345, "12345", 1'b1, 1'b1);

    // Reset after the second character of 65535.
    begin
      int lat;
      logic [7:0] c0;
      logic [7:0] c1;
      in_data = 32'd65535;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!char_valid && lat < 100) begin
        @(posedge clk); #1; lat++;
      end
      check("rst_seq_latency", 64'(lat), 64'd33);
      char_ready = 1'b1;
      c0 = char_data;
      @(posedge clk); #1;
      c1 = char_data;
      @(posedge clk); #1;
      check("rst_seq_char0", 64'(c0), 64'h36);
      check("rst_seq_char1", 64'(c1), 64'h35);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_emit_reset");
      @(posedge clk); #1;
      check_reset_outputs("held_reset");
      @(negedge clk);
      rst_n = 1'b1;
      char_ready = 1'b0;
      run_number(32'd7, "7", 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
